// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer.
// Contents:
//   OVF_CNT_W  width of the saturating dropped-word counter
//   nFrames()  number of frames held by a buffer of 2**depthLog2 words
//   stretchW() width of the counter that stretches the overflow indicator
package frame_buffer_pkg;

  localparam int OVF_CNT_W = 16;

  function automatic int nFrames(input int depthLog2, input int frameLog2);
    return 2 ** (depthLog2 - frameLog2);
  endfunction

  function automatic int stretchW(input int ovfStretch);
    return $clog2(ovfStretch + 1);
  endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port RAM, WIDTH x 2**AW words.
// There is one write port and one registered read port.
// There is no reset, so the array maps onto block RAM.
// Ports:
//   clk    clock
//   we     write enable
//   wAddr  write address
//   wData  write data
//   rAddr  read address, sampled every cycle
//   rData  word at rAddr, one cycle later
module frame_buffer_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic [AW-1:0]    rAddr,
  output logic [WIDTH-1:0] rData
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
    rData <= mem[rAddr];
  end

endmodule

// File: rtl/frame_buffer.sv
// Frame buffer between the packet assembler and the link handler.
// Incoming words are grouped into frames of 2**FRAMELOG2 words.
// A frame becomes visible to the reader only once it is complete.
// The writer can abandon a partial frame.
// The reader can rewind to the start of its current frame.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   WdAvail         PacketWd is valid this cycle
//   PacketWd        word to store
//   PacketReset     abandon the partial frame being written
//   DataVal         word at the read pointer (registered)
//   DataNext        read advance strobe (edge or level, see EDGE_NEXT)
//   DataReady       an unread committed word exists
//   DataFrameReset  rewind the read pointer to the current frame start
//   FrameReady      a committed frame is not yet fully read
//   FramesAvail     committed frames minus the reader's frame
//   DataOverf       stretched overflow indicator
//   OvfCount        dropped words, saturating
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAMELOG2   = 3,
  parameter int DEPTHLOG2   = 12,
  parameter int EDGE_NEXT   = 1,
  parameter int OVF_STRETCH = 2 ** 25
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           WdAvail,
  input  logic [WIDTH-1:0]               PacketWd,
  input  logic                           PacketReset,
  output logic [WIDTH-1:0]               DataVal,
  input  logic                           DataNext,
  output logic                           DataReady,
  input  logic                           DataFrameReset,
  output logic                           FrameReady,
  output logic [DEPTHLOG2-FRAMELOG2-1:0] FramesAvail,
  output logic                           DataOverf,
  output logic [OVF_CNT_W-1:0]           OvfCount
);

  localparam int NFRAMES = nFrames(DEPTHLOG2, FRAMELOG2);
  localparam int FW      = $clog2(NFRAMES);
  localparam int SW      = stretchW(OVF_STRETCH);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(OVF_STRETCH);

  logic [DEPTHLOG2-1:0] wp, rp, wpInc, rdBase;
  logic [FW-1:0]        commitF, rdF;
  logic                 ovfLatched, oldNext, full, wrEn, drop, nextEvt, adv;
  logic [SW-1:0]        stretch;
  logic [WIDTH-1:0]     ramQ_p1;
  logic                 rdValid_p1;

  always_comb begin
    wpInc   = wp + DEPTHLOG2'(1);
    rdF     = rp[DEPTHLOG2-1:FRAMELOG2];
    rdBase  = {rdF, {FRAMELOG2{1'b0}}};
    // The reader's whole current frame is protected, so a rewind never
    // finds overwritten data.
    full    = (wpInc == rdBase);
    drop    = ~PacketReset & WdAvail & (full | ovfLatched);
    wrEn    = ~PacketReset & WdAvail & ~full & ~ovfLatched;
    nextEvt = (EDGE_NEXT != 0) ? (DataNext & ~oldNext) : DataNext;
    adv     = nextEvt & DataReady;
  end

  assign DataReady   = ({commitF, {FRAMELOG2{1'b0}}} != rp);
  assign FrameReady  = (commitF != rdF);
  assign FramesAvail = commitF - rdF;
  assign DataOverf   = (stretch != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      commitF    <= '0;
      ovfLatched <= 1'b0;
      stretch    <= '0;
      OvfCount   <= '0;
      oldNext    <= 1'b0;
      rdValid_p1 <= 1'b0;
    end else begin
      if (PacketReset) begin
        wp         <= {wp[DEPTHLOG2-1:FRAMELOG2], {FRAMELOG2{1'b0}}};
        ovfLatched <= 1'b0;
      end else if (drop) begin
        ovfLatched <= 1'b1;
      end else if (wrEn) begin
        wp <= wpInc;
        if (wpInc[FRAMELOG2-1:0] == '0) begin
          commitF <= commitF + FW'(1);
        end
      end

      if (drop) begin
        stretch <= STRETCH_LOAD;
      end else if (stretch != '0) begin
        stretch <= stretch - SW'(1);
      end

      if (drop && (OvfCount != '1)) begin
        OvfCount <= OvfCount + OVF_CNT_W'(1);
      end

      oldNext <= DataNext;

      if (DataFrameReset) begin
        rp <= rdBase;
      end else if (adv) begin
        rp <= rp + DEPTHLOG2'(1);
      end

      rdValid_p1 <= 1'b1;
    end
  end

  frame_buffer_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTHLOG2)
  ) uRam (
    .clk   (clk),
    .we    (wrEn),
    .wAddr (wp),
    .wData (PacketWd),
    .rAddr (rp),
    .rData (ramQ_p1)
  );

  // ---- read stage p1 ----
  // The RAM has no reset, so the output is forced to zero until the first
  // read after reset has completed.
  assign DataVal = rdValid_p1 ? ramQ_p1 : '0;

endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // edge-mode instance
  logic        wdAvail, packetReset, dataNext, dataFrameReset;
  logic [15:0] packetWd, dataVal, ovfCount;
  logic        dataReady, frameReady, dataOverf;
  logic [1:0]  framesAvail;

  // level-mode instance
  logic        wdAvailB, packetResetB, dataNextB, dataFrameResetB;
  logic [15:0] packetWdB, dataValB, ovfCountB;
  logic        dataReadyB, frameReadyB, dataOverfB;
  logic [1:0]  framesAvailB;

  frame_buffer #(.WIDTH(16), .FRAMELOG2(3), .DEPTHLOG2(5), .EDGE_NEXT(1), .OVF_STRETCH(4)) dut (
    .clk(clk), .rst(rst), .WdAvail(wdAvail), .PacketWd(packetWd), .PacketReset(packetReset),
    .DataVal(dataVal), .DataNext(dataNext), .DataReady(dataReady), .DataFrameReset(dataFrameReset),
    .FrameReady(frameReady), .FramesAvail(framesAvail), .DataOverf(dataOverf), .OvfCount(ovfCount));

  frame_buffer #(.WIDTH(16), .FRAMELOG2(3), .DEPTHLOG2(5), .EDGE_NEXT(0), .OVF_STRETCH(4)) dutB (
    .clk(clk), .rst(rst), .WdAvail(wdAvailB), .PacketWd(packetWdB), .PacketReset(packetResetB),
    .DataVal(dataValB), .DataNext(dataNextB), .DataReady(dataReadyB), .DataFrameReset(dataFrameResetB),
    .FrameReady(frameReadyB), .FramesAvail(framesAvailB), .DataOverf(dataOverfB), .OvfCount(ovfCountB));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        wa;
    logic [15:0] wd;
    logic        nx;
    logic        eRdy;
    logic        eFrm;
    logic [1:0]  eFa;
    logic        chkV;
    logic [15:0] eVal;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic wa, input logic [15:0] wd, input logic nx,
                              input logic eRdy, input logic eFrm, input logic [1:0] eFa,
                              input logic chkV, input logic [15:0] eVal);
    vec_t v;
    v.wa = wa; v.wd = wd; v.nx = nx; v.eRdy = eRdy; v.eFrm = eFrm;
    v.eFa = eFa; v.chkV = chkV; v.eVal = eVal;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic wa, input logic [15:0] wd, input logic pr,
                      input logic nx, input logic fr);
    @(negedge clk);
    wdAvail = wa; packetWd = wd; packetReset = pr; dataNext = nx; dataFrameReset = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic stepB(input logic wa, input logic [15:0] wd, input logic nx);
    @(negedge clk);
    wdAvailB = wa; packetWdB = wd; dataNextB = nx;
    @(posedge clk);
    #1;
  endtask

  // One rising DataNext edge per word; DataVal holds the current word at the edge.
  task automatic readFrame(input string name, input logic [15:0] first);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("%s.word%0d", name, i), dataVal, first + 16'(i));
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic chkAllZero(input string name);
    chk({name, ".dataVal"}, dataVal, 0);
    chk({name, ".dataReady"}, dataReady, 0);
    chk({name, ".frameReady"}, frameReady, 0);
    chk({name, ".framesAvail"}, framesAvail, 0);
    chk({name, ".dataOverf"}, dataOverf, 0);
    chk({name, ".ovfCount"}, ovfCount, 0);
  endtask

  initial begin
    tbl[0]  = mk(1, 16'h1000, 0, 0, 0, 0, 0, 16'h0);
    tbl[1]  = mk(1, 16'h1001, 0, 0, 0, 0, 0, 16'h0);
    tbl[2]  = mk(1, 16'h1002, 0, 0, 0, 0, 0, 16'h0);
    tbl[3]  = mk(1, 16'h1003, 0, 0, 0, 0, 0, 16'h0);
    tbl[4]  = mk(1, 16'h1004, 0, 0, 0, 0, 0, 16'h0);
    tbl[5]  = mk(1, 16'h1005, 0, 0, 0, 0, 0, 16'h0);
    tbl[6]  = mk(1, 16'h1006, 0, 0, 0, 0, 0, 16'h0);
    tbl[7]  = mk(1, 16'h1007, 0, 1, 1, 1, 1, 16'h1000);
    tbl[8]  = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1000);
    tbl[9]  = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1001);
    tbl[10] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1001);
    tbl[11] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1002);
    tbl[12] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1002);
    tbl[13] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1003);
    tbl[14] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1003);
    tbl[15] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1004);
    tbl[16] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1004);
    tbl[17] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1005);
    tbl[18] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1005);
    tbl[19] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1006);
    tbl[20] = mk(0, 16'h0, 1, 1, 1, 1, 1, 16'h1006);
    tbl[21] = mk(0, 16'h0, 0, 1, 1, 1, 1, 16'h1007);
    tbl[22] = mk(0, 16'h0, 1, 0, 0, 0, 1, 16'h1007);
    tbl[23] = mk(0, 16'h0, 0, 0, 0, 0, 0, 16'h0);

    wdAvail = 0; packetWd = 0; packetReset = 0; dataNext = 0; dataFrameReset = 0;
    wdAvailB = 0; packetWdB = 0; packetResetB = 0; dataNextB = 0; dataFrameResetB = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chkAllZero("resetHeld");
    @(negedge clk);
    rst = 1'b0;
    step(0, 16'h0, 0, 0, 0);
    chk("afterReset.dataReady", dataReady, 0);
    chk("afterReset.framesAvail", framesAvail, 0);

    // frame commit and read
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].wa, tbl[i].wd, 1'b0, tbl[i].nx, 1'b0);
      chk($sformatf("vec%0d.dataReady", i), dataReady, tbl[i].eRdy);
      chk($sformatf("vec%0d.frameReady", i), frameReady, tbl[i].eFrm);
      chk($sformatf("vec%0d.framesAvail", i), framesAvail, tbl[i].eFa);
      chk($sformatf("vec%0d.ovfCount", i), ovfCount, 0);
      if (tbl[i].chkV) chk($sformatf("vec%0d.dataVal", i), dataVal, tbl[i].eVal);
    end

    // writer abort
    for (int i = 0; i < 5; i++) step(1, 16'hAA00 + 16'(i), 0, 0, 0);
    step(1, 16'hAAFF, 1, 0, 0);
    chk("abort.framesAvail", framesAvail, 0);
    chk("abort.dataReady", dataReady, 0);
    chk("abort.frameReady", frameReady, 0);
    chk("abort.ovfCount", ovfCount, 0);
    for (int i = 0; i < 8; i++) step(1, 16'h2000 + 16'(i), 0, 0, 0);
    chk("abort.commit.frameReady", frameReady, 1);
    chk("abort.commit.framesAvail", framesAvail, 1);
    chk("abort.commit.dataVal", dataVal, 16'h2000);
    readFrame("abortRead", 16'h2000);
    chk("abortRead.dataReady", dataReady, 0);
    chk("abortRead.framesAvail", framesAvail, 0);

    // overflow
    for (int i = 0; i < 31; i++) step(1, 16'h3000 + 16'(i), 0, 0, 0);
    chk("ovf.fill.framesAvail", framesAvail, 3);
    chk("ovf.fill.dataOverf", dataOverf, 0);
    chk("ovf.fill.ovfCount", ovfCount, 0);
    step(1, 16'h30FE, 0, 0, 0);
    chk("ovf.drop1.dataOverf", dataOverf, 1);
    chk("ovf.drop1.ovfCount", ovfCount, 1);
    step(1, 16'h30FF, 0, 0, 0);
    chk("ovf.drop2.dataOverf", dataOverf, 1);
    chk("ovf.drop2.ovfCount", ovfCount, 2);
    chk("ovf.drop2.framesAvail", framesAvail, 3);
    for (int k = 1; k <= 4; k++) begin
      step(0, 16'h0, 0, 0, 0);
      chk($sformatf("ovf.stretch%0d", k), dataOverf, (k < 4) ? 1 : 0);
    end
    chk("ovf.hold.ovfCount", ovfCount, 2);
    step(0, 16'h0, 1, 0, 0);
    chk("ovf.pktReset.framesAvail", framesAvail, 3);
    readFrame("ovfRead", 16'h3000);
    chk("ovfRead.framesAvail", framesAvail, 2);
    for (int i = 0; i < 8; i++) step(1, 16'h5000 + 16'(i), 0, 0, 0);
    chk("ovf.refill.framesAvail", framesAvail, 3);
    chk("ovf.refill.ovfCount", ovfCount, 2);
    chk("ovf.refill.dataOverf", dataOverf, 0);

    // reader rewind
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0, 0, 1, 0);
      chk($sformatf("rewind.pre%0d", i), dataVal, 16'h3008 + 16'(i));
      step(0, 16'h0, 0, 0, 0);
    end
    step(0, 16'h0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0);
    chk("rewind.dataVal", dataVal, 16'h3008);
    chk("rewind.dataReady", dataReady, 1);
    chk("rewind.framesAvail", framesAvail, 3);
    readFrame("rewindRead", 16'h3008);
    chk("rewindRead.framesAvail", framesAvail, 2);

    // asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chkAllZero("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    step(0, 16'h0, 0, 0, 0);
    chk("asyncRelease.dataReady", dataReady, 0);
    chk("asyncRelease.framesAvail", framesAvail, 0);

    // level-mode read strobe
    for (int i = 0; i < 8; i++) stepB(1, 16'h4000 + 16'(i), 0);
    stepB(0, 16'h0, 0);
    chk("level.frameReady", frameReadyB, 1);
    chk("level.dataVal0", dataValB, 16'h4000);
    for (int k = 1; k <= 8; k++) begin
      stepB(0, 16'h0, 1);
      chk($sformatf("level.word%0d", k - 1), dataValB, 16'h4000 + 16'(k - 1));
    end
    chk("level.dataReady", dataReadyB, 0);
    chk("level.framesAvail", framesAvailB, 0);
    stepB(0, 16'h0, 1);
    chk("level.stop.dataReady", dataReadyB, 0);
    chk("level.stop.frameReady", frameReadyB, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Single-clock, parametrised successor to the packet output buffer. Sits between the packet assembler and the serial/USB/other link handler.
- Accepts words from the assembler and groups them into fixed-size frames. A frame is visible to the reader only once it is complete. The writer can abandon a partial frame; the reader can rewind to the start of its current frame.
- Adds over the previous generation: parametrised data width, frame length and depth; a frames-available count; a saturating dropped-word counter; selectable edge or level read strobe; a parametrised overflow-indication stretch.

Parameters:
- WIDTH, 16, data word width.
- FRAMELOG2, 3, log2 of words per frame.
- DEPTHLOG2, 12, log2 of buffer words; must be > FRAMELOG2.
- EDGE_NEXT, 1, 1 = advance on rising edge of DataNext; 0 = advance on every cycle DataNext is high.
- OVF_STRETCH, 2**25, cycles DataOverf stays high after an overflow event.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- WdAvail  in  1  PacketWd valid this cycle.
- PacketWd  in  WIDTH  word to store.
- PacketReset  in  1  abandon the partial frame being written.
- DataVal  out  WIDTH  word at the read pointer (registered).
- DataNext  in  1  read advance strobe.
- DataReady  out  1  an unread committed word exists.
- DataFrameReset  in  1  rewind the read pointer to the current frame start.
- FrameReady  out  1  at least one committed frame is not yet fully read.
- FramesAvail  out  DEPTHLOG2-FRAMELOG2  committed frames minus the reader's frame.
- DataOverf  out  1  stretched overflow indicator.
- OvfCount  out  16  dropped words, saturating at 0xFFFF.

Behaviour:
- Reset is asynchronous on rst high. wp, rp, commitF, ovfLatched, stretch, OvfCount, oldNext and DataVal all clear to 0. Every output reads 0 while rst is held.
- Pointers: wp and rp are DEPTHLOG2 bits and wrap modulo 2**DEPTHLOG2.
  - commitF is the committed write frame index (DEPTHLOG2-FRAMELOG2 bits).
  - rdF = rp[DEPTHLOG2-1:FRAMELOG2].
  - rdBase = {rdF, FRAMELOG2'b0}.
- full = ((wp+1) mod 2**DEPTHLOG2 == rdBase). The reader's whole current frame is protected, so rewind is always safe. One word is sacrificed, so at most NFRAMES-1 frames can ever be committed.
- Write cycle, with PacketReset priority over WdAvail:
  - PacketReset: wp <= {wp[top:FRAMELOG2], 0}, ovfLatched <= 0, and any WdAvail in the same cycle is dropped (not counted).
  - Else if WdAvail and (full or ovfLatched): word dropped, ovfLatched <= 1, OvfCount++ (saturating), stretch reloads to OVF_STRETCH.
  - Else if WdAvail: mem[wp] <= PacketWd, wp <= wp+1. If (wp+1) low FRAMELOG2 bits == 0, then commitF <= commitF+1.
- A latched overflow drops every word until PacketReset; the partial frame is then discarded.
- DataReady = ({commitF, 0} != rp), combinational.
- FrameReady = (commitF != rdF), combinational.
- FramesAvail = commitF - rdF, modulo.
- DataOverf = (stretch != 0). stretch decrements by 1 per cycle when not reloading.
- Read advance, adv:
  - EDGE_NEXT=1: adv = DataNext & ~oldNext & DataReady.
  - EDGE_NEXT=0: adv = DataNext & DataReady.
  - oldNext <= DataNext every cycle.
- Read cycle, with DataFrameReset priority: rp <= rdBase. Else if adv: rp <= rp+1. Crossing a frame boundary updates rdBase, freeing the old frame for the writer in the same cycle.
- DataVal <= mem[rp] every cycle, giving 1-cycle latency from an rp change.
  - The reader never reads an uncommitted word, so no write/read bypass is needed.
  - A same-cycle write to the freed frame and a read are at different addresses.
- Reset mid-frame: all state clears immediately and buffered data is lost. Memory contents are not cleared.

Decomposition:
- Package frame_buffer_pkg holds:
  - localparam NFRAMES = 2**(DEPTHLOG2-FRAMELOG2);
  - the stretch counter width, $clog2(OVF_STRETCH+1);
  - the OvfCount width, 16.
- Sub-module frame_buffer_ram: simple dual-port RAM, WIDTH x 2**DEPTHLOG2, with one write port, one registered read port, and no reset, so it infers block RAM.

Test Plan:
(All scenarios use WIDTH=16, FRAMELOG2=3, DEPTHLOG2=5, EDGE_NEXT=1, OVF_STRETCH=4.)
- Reset: pulse rst asynchronously between clock edges. All outputs go to 0 immediately; after release, DataReady=0 and FramesAvail=0.
- Frame commit and read:
  - Write 0x1000..0x1006. DataReady stays 0.
  - Write 0x1007. One cycle later FrameReady=1, FramesAvail=1, DataVal=0x1000.
  - Give 8 DataNext rising edges. DataVal steps through 0x1001..0x1007. After the 8th edge, DataReady=0 and FramesAvail=0.
- Writer abort:
  - Write 5 words, then assert PacketReset together with WdAvail. Nothing is committed and OvfCount=0.
  - Write 0x2000..0x2007. Reading returns 0x2000 first.
- Overflow:
  - Write 31 words with no reads. FramesAvail=3.
  - Writes 32 and 33: DataOverf=1 for 4 cycles after the last drop, OvfCount=2, FramesAvail still 3.
  - PacketReset, then read one frame; afterwards 8 more writes commit and FramesAvail=3.
- Reader rewind:
  - Read 3 words of frame 0, then assert DataFrameReset together with a DataNext edge. rp=0 and DataVal=the first word.
  - Reading the full frame again returns identical data.
- Level mode (EDGE_NEXT=0): hold DataNext high for 8 cycles with one frame committed. DataVal advances every cycle and rp stops at 8 with DataReady=0.
